// File: rtl/ps_stck_pkg.sv
// ps_stck_pkg
// Shared definitions for the program-sequencer stack unit.
//   - STK_* : bit positions inside the 7-bit sticky/status word
//             {lp_ovf, lp_full, lp_empty, pc_unf, pc_ovf, pc_full, pc_empty}
//   - lp_entry_t : loop-stack entry layout at the default 16-bit widths
//                  (loop top, loop end address, loop count), MSB first.
package ps_stck_pkg;

  localparam int STK_PC_EMPTY = 0;
  localparam int STK_PC_FULL  = 1;
  localparam int STK_PC_OVF   = 2;
  localparam int STK_PC_UNF   = 3;
  localparam int STK_LP_EMPTY = 4;
  localparam int STK_LP_FULL  = 5;
  localparam int STK_LP_OVF   = 6;
  localparam int STK_W        = 7;

  localparam int LP_AW = 16;
  localparam int LP_CW = 16;

  typedef struct packed {
    logic [LP_AW-1:0] top;
    logic [LP_AW-1:0] lend;
    logic [LP_CW-1:0] cnt;
  } lp_entry_t;

endpackage

// File: rtl/ps_lifo.sv
// ps_lifo
// Generic register-file LIFO used for both the PC stack and the loop stack.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointer only)
//   i_en              update enable (stall/halt gating from the parent)
//   i_push, i_wdata   push request and data
//   i_pop             pop request; push+pop together replaces the top entry
//   i_repl, i_rdata   in-place rewrite of the current top entry (ignored on
//                     pop or when empty); may coincide with a plain push
//   o_top             top entry, 0 when empty
//   o_pntr            occupancy
//   o_full, o_empty   occupancy flags
//   o_ovf, o_unf      single-cycle pulses: push on full / pop on empty
module ps_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_repl,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_top,
  output logic [PW-1:0]    o_pntr,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_pntr;
  logic [PW-1:0]    w_nxt_pntr;
  logic [PW-1:0]    w_top_pntr;
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_wr_idx;
  logic             w_wr;
  logic             w_repl;

  assign o_empty    = (r_pntr == '0);
  assign o_full     = (r_pntr == PW'(DEPTH));
  assign w_top_pntr = r_pntr - PW'(1);
  assign w_top_idx  = w_top_pntr[IW-1:0];
  assign o_top      = o_empty ? '0 : r_mem[w_top_idx];
  assign o_pntr     = r_pntr;

  always_comb begin
    w_nxt_pntr = r_pntr;
    w_wr       = 1'b0;
    w_wr_idx   = r_pntr[IW-1:0];
    w_repl     = 1'b0;
    o_ovf      = 1'b0;
    o_unf      = 1'b0;
    if (i_en) begin
      if (i_pop && o_empty) begin
        o_unf = 1'b1;
      end else if (i_push && i_pop) begin
        // pop-then-push collapses into an overwrite of the current top
        w_wr     = 1'b1;
        w_wr_idx = w_top_idx;
      end else if (i_pop) begin
        w_nxt_pntr = w_top_pntr;
      end else if (i_push) begin
        if (o_full) begin
          o_ovf = 1'b1;
        end else begin
          w_wr       = 1'b1;
          w_nxt_pntr = r_pntr + PW'(1);
        end
      end
      w_repl = i_repl & ~o_empty & ~i_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pntr <= '0;
    end else begin
      r_pntr <= w_nxt_pntr;
    end
  end

  // Storage is not reset: entries above the pointer are never observed.
  always_ff @(posedge clk) begin
    if (w_repl) begin
      r_mem[w_top_idx] <= i_rdata;
    end
    if (w_wr) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/ps_pc_loop_stck.sv
// ps_pc_loop_stck
// Program-sequencer stack unit: PC (return-address) stack plus loop stack
// with loop-end detection, loop-back / zero-count-skip redirects and sticky
// status.  Optional macro PS_LCNTR_WR_EN adds ps_lcntr_wr/ps_lcntr_wdt, a
// ureg write path to the innermost loop counter.
// Ports:
//   clk, rst (async active-low), stallb (0 = freeze + no redirects)
//   ps_fetch_vld/ps_faddr            fetch address for loop-end compare
//   ps_call/ps_call_addr, ps_rtrn    call push / return pop
//   ps_pshstck/ps_stck_wdt, ps_popstck  explicit push / pop
//   ps_loop/_top/_end/_cnt           loop-start instruction
//   ps_stcky_clr                     clears the sticky ovf/unf bits
//   ps_pcstck, ps_pcstck_pntr        PC stack top / occupancy
//   ps_curlcntr, ps_laddr, ps_lp_pntr  innermost loop count / end / occupancy
//   ps_lp_jmp, ps_lp_skip, ps_lp_jmp_addr  fetch redirects
//   ps_stcky, ps_halt                status word, halt = pc_ovf | lp_ovf
module ps_pc_loop_stck
  import ps_stck_pkg::*;
#(
  parameter int AW       = 16,
  parameter int CW       = 16,
  parameter int PC_DEPTH = 8,
  parameter int LP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stallb,
  input  logic                          ps_fetch_vld,
  input  logic [AW-1:0]                 ps_faddr,
  input  logic                          ps_call,
  input  logic [AW-1:0]                 ps_call_addr,
  input  logic                          ps_rtrn,
  input  logic                          ps_pshstck,
  input  logic                          ps_popstck,
  input  logic [AW-1:0]                 ps_stck_wdt,
  input  logic                          ps_loop,
  input  logic [AW-1:0]                 ps_loop_top,
  input  logic [AW-1:0]                 ps_loop_end,
  input  logic [CW-1:0]                 ps_loop_cnt,
  input  logic                          ps_stcky_clr,
`ifdef PS_LCNTR_WR_EN
  input  logic                          ps_lcntr_wr,
  input  logic [CW-1:0]                 ps_lcntr_wdt,
`endif
  output logic [AW-1:0]                 ps_pcstck,
  output logic [$clog2(PC_DEPTH+1)-1:0] ps_pcstck_pntr,
  output logic [CW-1:0]                 ps_curlcntr,
  output logic [AW-1:0]                 ps_laddr,
  output logic [$clog2(LP_DEPTH+1)-1:0] ps_lp_pntr,
  output logic                          ps_lp_jmp,
  output logic [AW-1:0]                 ps_lp_jmp_addr,
  output logic                          ps_lp_skip,
  output logic [STK_W-1:0]              ps_stcky,
  output logic                          ps_halt
);

  typedef struct packed {
    logic [AW-1:0] top;
    logic [AW-1:0] lend;
    logic [CW-1:0] cnt;
  } lp_ent_t;

  logic          w_en;
  logic          w_pc_push, w_pc_pop, w_pc_full, w_pc_empty, w_pc_ovf, w_pc_unf;
  logic [AW-1:0] w_pc_wdata;
  lp_ent_t       w_lp_top, w_lp_new, w_lp_mod;
  logic          w_lp_push, w_lp_pop, w_lp_repl;
  logic          w_lp_full, w_lp_empty, w_lp_ovf, w_lp_unf_unused;
  logic          w_hit, w_cnt_gt1;
  logic          r_pc_ovf, r_pc_unf, r_lp_ovf;

  assign ps_halt = r_pc_ovf | r_lp_ovf;
  assign w_en    = stallb & ~ps_halt;

  // PC stack: a call outranks an explicit push for the write data
  assign w_pc_push  = ps_call | ps_pshstck;
  assign w_pc_pop   = ps_rtrn | ps_popstck;
  assign w_pc_wdata = ps_call ? ps_call_addr : ps_stck_wdt;

  ps_lifo #(.WIDTH(AW), .DEPTH(PC_DEPTH)) u_pc_stck (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_en),
    .i_push  (w_pc_push),
    .i_pop   (w_pc_pop),
    .i_wdata (w_pc_wdata),
    .i_repl  (1'b0),
    .i_rdata ('0),
    .o_top   (ps_pcstck),
    .o_pntr  (ps_pcstck_pntr),
    .o_full  (w_pc_full),
    .o_empty (w_pc_empty),
    .o_ovf   (w_pc_ovf),
    .o_unf   (w_pc_unf)
  );

  // Loop-end detection looks at the innermost loop only; an outer loop
  // ending at the same address is caught on its next fetch.
  assign ps_curlcntr = w_lp_top.cnt;
  assign ps_laddr    = w_lp_top.lend;
  assign w_hit       = ps_fetch_vld & ~w_lp_empty & (ps_faddr == w_lp_top.lend);
  assign w_cnt_gt1   = (w_lp_top.cnt > CW'(1));
  // count 0 (only reachable through a counter write) also falls through
  assign w_lp_pop    = w_hit & ~w_cnt_gt1;
  assign w_lp_push   = ps_loop & (ps_loop_cnt != '0);
  assign w_lp_new    = {ps_loop_top, ps_loop_end, ps_loop_cnt};

  always_comb begin
    w_lp_mod  = w_lp_top;
    w_lp_repl = 1'b0;
    if (w_hit && w_cnt_gt1) begin
      w_lp_repl    = 1'b1;
      w_lp_mod.cnt = w_lp_top.cnt - CW'(1);
    end
`ifdef PS_LCNTR_WR_EN
    if (ps_lcntr_wr) begin
      w_lp_repl    = 1'b1;
      w_lp_mod.cnt = ps_lcntr_wdt;
    end
`endif
  end

  ps_lifo #(.WIDTH($bits(lp_ent_t)), .DEPTH(LP_DEPTH)) u_lp_stck (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_en),
    .i_push  (w_lp_push),
    .i_pop   (w_lp_pop),
    .i_wdata (w_lp_new),
    .i_repl  (w_lp_repl),
    .i_rdata (w_lp_mod),
    .o_top   (w_lp_top),
    .o_pntr  (ps_lp_pntr),
    .o_full  (w_lp_full),
    .o_empty (w_lp_empty),
    .o_ovf   (w_lp_ovf),
    .o_unf   (w_lp_unf_unused)
  );

  assign ps_lp_jmp  = w_en & w_hit & w_cnt_gt1;
  assign ps_lp_skip = w_en & ps_loop & (ps_loop_cnt == '0);

  // The skip belongs to an instruction further down the pipe than the
  // fetch being compared, so it owns the shared target when both fire.
  always_comb begin
    ps_lp_jmp_addr = '0;
    if (ps_lp_skip) begin
      ps_lp_jmp_addr = ps_loop_end + AW'(1);
    end else if (ps_lp_jmp) begin
      ps_lp_jmp_addr = w_lp_top.top;
    end
  end

  // Clear is not gated by halt so a halted sequencer can be recovered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc_ovf <= 1'b0;
      r_pc_unf <= 1'b0;
      r_lp_ovf <= 1'b0;
    end else if (ps_stcky_clr) begin
      r_pc_ovf <= 1'b0;
      r_pc_unf <= 1'b0;
      r_lp_ovf <= 1'b0;
    end else begin
      r_pc_ovf <= r_pc_ovf | w_pc_ovf;
      r_pc_unf <= r_pc_unf | w_pc_unf;
      r_lp_ovf <= r_lp_ovf | w_lp_ovf;
    end
  end

  always_comb begin
    ps_stcky               = '0;
    ps_stcky[STK_PC_EMPTY] = w_pc_empty;
    ps_stcky[STK_PC_FULL]  = w_pc_full;
    ps_stcky[STK_PC_OVF]   = r_pc_ovf;
    ps_stcky[STK_PC_UNF]   = r_pc_unf;
    ps_stcky[STK_LP_EMPTY] = w_lp_empty;
    ps_stcky[STK_LP_FULL]  = w_lp_full;
    ps_stcky[STK_LP_OVF]   = r_lp_ovf;
  end

endmodule

// File: doc/ps_pc_loop_stck.md
Name: ps_pc_loop_stck

Overview:
- Parametrised program-sequencer stack unit: a PC stack of depth PC_DEPTH plus a loop stack of depth LP_DEPTH.
- Loop stack entries are {loop top, loop end address, loop count}.
- Supports nested loops, nested calls, explicit push/pop and sticky empty/full/overflow/underflow status.
- Sits beside the fetch-address logic. It supplies the return address, a loop-back redirect and a loop-skip redirect to the fetch stage, and PCSTCK/LCNTR/LADDR/STKY values to the ureg read path.

Parameters:
- AW, 16, address width (PC, stack entries, loop addresses)
- CW, 16, loop counter width
- PC_DEPTH, 8, PC stack entries (>=2)
- LP_DEPTH, 4, loop stack entries (>=2)

Ports:
- clk  in  1  single clock, posedge active
- rst  in  1  asynchronous active-low reset
- stallb  in  1  0 = pipeline stalled: no state update, redirects forced 0
- ps_fetch_vld  in  1  ps_faddr holds a valid fetch this cycle
- ps_faddr  in  AW  current fetch address
- ps_call  in  1  push ps_call_addr (return address)
- ps_call_addr  in  AW  return address to push
- ps_rtrn  in  1  pop PC stack
- ps_pshstck  in  1  explicit push of ps_stck_wdt
- ps_popstck  in  1  explicit pop
- ps_stck_wdt  in  AW  explicit push data
- ps_loop  in  1  loop-start instruction
- ps_loop_top  in  AW  first address of loop body
- ps_loop_end  in  AW  last address of loop body
- ps_loop_cnt  in  CW  iteration count
- ps_stcky_clr  in  1  clears sticky bits [3:2] and [6]
- ps_pcstck  out  AW  PC stack top (0 when empty)
- ps_pcstck_pntr  out  $clog2(PC_DEPTH+1)  PC stack occupancy
- ps_curlcntr  out  CW  innermost loop counter (0 when loop stack empty)
- ps_laddr  out  AW  innermost loop end (0 when empty)
- ps_lp_pntr  out  $clog2(LP_DEPTH+1)  loop stack occupancy
- ps_lp_jmp  out  1  redirect fetch to ps_lp_jmp_addr
- ps_lp_jmp_addr  out  AW  loop-back target
- ps_lp_skip  out  1  zero-count loop: redirect fetch to ps_loop_end+1
- ps_stcky  out  7  {lp_ovf, lp_full, lp_empty, pc_unf, pc_ovf, pc_full, pc_empty}
- ps_halt  out  1  = ps_stcky[2] | ps_stcky[6]

Behaviour:
- Reset (async, rst=0):
  - both pointers 0; all outputs 0 except ps_stcky=7'b0010001 (both empty flags set).
  - Reset mid-operation discards all entries immediately.
- Gating: all updates occur on posedge clk only when stallb=1 and ps_halt=0. ps_lp_jmp and ps_lp_skip are combinational and gated by stallb & ~ps_halt.
- PC stack push/pop:
  - Push request = ps_call|ps_pshstck; data ps_call_addr if ps_call, else ps_stck_wdt.
  - Pop request = ps_rtrn|ps_popstck.
  - Push and pop in the same cycle: top entry replaced, pointer unchanged (legal only when not empty).
  - Pop on empty: pointer held, pc_unf set.
  - Push on full: no write, pointer held, pc_ovf set (halts).
  - ps_pcstck reflects the new top the cycle after the update (1-cycle latency).
- Loop end detection (combinational):
  - loop_hit = ps_fetch_vld & ~lp_empty & (ps_faddr==ps_laddr).
  - If loop_hit & ps_curlcntr>1: ps_lp_jmp=1, ps_lp_jmp_addr=top.loop_top; counter decrements next edge.
  - If loop_hit & ps_curlcntr==1: no redirect; loop stack popped next edge (fall through).
  - Only the innermost loop is compared. An outer loop sharing the same end address is detected on the next fetch of that address.
- Loop push:
  - ps_loop & ps_loop_cnt!=0 pushes {ps_loop_top, ps_loop_end, ps_loop_cnt}.
  - ps_loop & ps_loop_cnt==0: no push; ps_lp_skip=1 combinationally.
  - Loop push on full: lp_ovf set, no write.
  - Same-cycle loop_hit-pop and ps_loop push: the pop is applied first, then the push (net replace).
- Arithmetic: counter decrement modulo 2^CW (underflow impossible since 0 is never stored); ps_loop_end+1 wraps modulo 2^AW.
- Flags:
  - Full/empty bits track occupancy combinationally from the registered pointers.
  - Overflow/underflow bits are sticky until ps_stcky_clr or reset. Clear has priority over a same-cycle set.

Optional Feature:
- Macro: PS_LCNTR_WR_EN.
- With it: adds ports ps_lcntr_wr (in 1) and ps_lcntr_wdt (in CW). A ureg write overwrites the top loop counter next edge and takes priority over a same-cycle decrement. Writing 0 pops the loop at the next loop_hit with no redirect. Ignored when the loop stack is empty.
- Without it: ports absent; counter is modified only by push/decrement.

Decomposition:
- Package ps_stck_pkg: stcky bit index localparams (STK_PC_EMPTY..STK_LP_OVF), loop-entry struct typedef parametrised via AW/CW localparams.
- Sub-module ps_lifo: generic LIFO (WIDTH, DEPTH; push, pop, replace, top, pntr, full, empty, ovf/unf pulses), instantiated once per stack.

Test Plan:
- Call with ps_call_addr=16'h0040 ×3, then ps_rtrn ×3 -> ps_pcstck sequence 0040/0040/0040 then pops; pntr 1,2,3,2,1,0; pc_empty set at end.
- 9 pushes with PC_DEPTH=8 -> pntr stays 8, pc_ovf=1, ps_halt=1; ps_stcky_clr then reset -> ps_stcky=7'b0010001.
- Loop top=0x10, end=0x12, cnt=3; fetch 0x10..0x12 repeatedly -> ps_lp_jmp to 0x10 twice, third pass falls through, lp_empty=1.
- Nested loops (outer cnt=2, end=0x20; inner cnt=2, end=0x1E) -> inner redirects once per outer pass; total fetches of 0x1E = 4; both stacks empty at finish.
- ps_loop with cnt=0, end=0xFFFF -> ps_lp_skip=1, redirect address 0x0000, lp_pntr unchanged.
- stallb=0 during a loop_hit -> ps_lp_jmp=0, counter unchanged; after release the hit redirects normally.
